// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports.
// Data has priority, one transaction is outstanding at a time, and stall holds until every pending request is served.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_RESP = 3'd2,
    I_REQ  = 3'd3,
    I_RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        inst_done_q, inst_done_d;
  logic        data_done_q, data_done_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_pend, data_pend;

  // A port still needs service only while it asks and has not yet been answered.
  assign inst_pend = inst_req & ~inst_done_q;
  assign data_pend = data_req & ~data_done_q;
  assign stall     = inst_pend | data_pend;

  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    // Done flags live for one pipeline step: they clear on the edge the pipeline advances.
    inst_done_d  = stall ? inst_done_q : 1'b0;
    data_done_d  = stall ? data_done_q : 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    mem_req      = 1'b0;
    mem_wen      = 4'h0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;

    case (state_q)
      IDLE: begin
        if (data_pend) begin
          state_d = D_REQ;
        end else if (inst_pend) begin
          state_d = I_REQ;
        end
      end
      D_REQ: begin
        mem_req   = 1'b1;
        mem_wen   = data_wen;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        if (mem_gnt) begin
          state_d = D_RESP;
        end
      end
      D_RESP: begin
        if (mem_rvalid) begin
          data_rdata_d = mem_rdata;
          data_done_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      I_REQ: begin
        mem_req  = 1'b1;
        mem_addr = inst_addr;
        if (mem_gnt) begin
          state_d = I_RESP;
        end
      end
      I_RESP: begin
        if (mem_rvalid) begin
          inst_rdata_d = mem_rdata;
          inst_done_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scripted memory responder with programmable waits, a
// vector table, hand-written corner sequences, and randomized pipeline steps.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        stall;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_rdata(inst_rdata),
    .data_req  (data_req),
    .data_wen  (data_wen),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  txn_t        log_q[$];
  logic [31:0] script_q[$];
  int          gnt_wait = 0;
  int          rv_wait  = 0;

  logic [31:0] exp_inst;
  logic [31:0] exp_data;
  bit          data_known;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory responder: decides gnt/rvalid for the current cycle on the falling edge.
  bit          pend;
  int          gcnt;
  int          rcnt;
  logic [31:0] pend_word;
  always @(negedge clk) begin
    if (!rst) begin
      pend = 0; gcnt = 0; rcnt = 0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
    end else begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
      if (!mem_req) begin
        chk32("idle_bus_zero", {31'h0, (mem_addr != 0 || mem_wen != 0 || mem_wdata != 0)}, 32'h0);
      end
      if (pend) begin
        chk32("single_outstanding", {31'h0, mem_req}, 32'h0);
        if (rcnt == rv_wait) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend_word;
          pend       = 0;
        end else begin
          rcnt++;
        end
      end else if (mem_req) begin
        if (gcnt == gnt_wait) begin
          mem_gnt = 1'b1;
          log_q.push_back('{addr: mem_addr, wen: mem_wen, wdata: mem_wdata});
          pend_word = (script_q.size() != 0) ? script_q.pop_front() : (32'hC0FFEE00 ^ mem_addr);
          pend = 1; rcnt = 0; gcnt = 0;
        end else begin
          gcnt++;
        end
      end
    end
  end

  // One pipeline step: present requests, wait for release, check against the model.
  // Entered and left #1 after a rising edge.
  task automatic run_op(input bit ireq, input logic [31:0] iaddr, input logic [31:0] iword,
                        input bit dreq, input logic [3:0] dwen, input logic [31:0] daddr,
                        input logic [31:0] dwdata, input logic [31:0] dword,
                        input int gw, input int rw, output int cycles);
    txn_t exp_q[$];
    int   exp_cycles;
    log_q.delete();
    script_q.delete();
    gnt_wait = gw;
    rv_wait  = rw;
    exp_cycles = 0;
    if (dreq) begin
      exp_q.push_back('{addr: daddr, wen: dwen, wdata: dwdata});
      script_q.push_back(dword);
      exp_cycles += 3 + gw + rw;
    end
    if (ireq) begin
      exp_q.push_back('{addr: iaddr, wen: 4'h0, wdata: 32'h0});
      script_q.push_back(iword);
      exp_cycles += 3 + gw + rw;
    end
    inst_req = ireq; inst_addr = iaddr;
    data_req = dreq; data_wen = dwen; data_addr = daddr; data_wdata = dwdata;
    cycles = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      cycles++;
      if (cycles > 300) begin
        chk32("release_timeout", 32'(cycles), 32'(exp_cycles));
        break;
      end
    end
    if (dreq) begin
      exp_data   = dword;
      data_known = (dwen == 4'h0);
    end
    if (ireq) exp_inst = iword;
    chk32("stall_cycles", 32'(cycles), 32'(exp_cycles));
    chk32("txn_count", 32'(log_q.size()), 32'(exp_q.size()));
    if (log_q.size() == exp_q.size()) begin
      foreach (exp_q[k]) begin
        chk32("txn_addr", log_q[k].addr, exp_q[k].addr);
        chk32("txn_wen", {28'h0, log_q[k].wen}, {28'h0, exp_q[k].wen});
        chk32("txn_wdata", log_q[k].wdata, exp_q[k].wdata);
      end
    end
    chk32("inst_rdata", inst_rdata, exp_inst);
    if (data_known) chk32("data_rdata", data_rdata, exp_data);
    @(posedge clk);
    #1;
    inst_req = 1'b0;
    data_req = 1'b0;
  endtask

  typedef struct {
    bit          ireq;
    logic [31:0] iaddr;
    logic [31:0] iword;
    bit          dreq;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] dword;
    int          gw;
    int          rw;
    int          exp_cycles;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    bit          chk_d;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;
    rst = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0;
    data_req = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    exp_inst = 32'h0; exp_data = 32'h0; data_known = 1;

    #3;
    chk32("rst_stall_follows_req", {31'h0, stall}, 32'h1);
    chk32("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_inst_rdata", inst_rdata, 32'h0);
    chk32("rst_data_rdata", data_rdata, 32'h0);
    inst_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Fetch-only, zero-wait, cycle by cycle.
    log_q.delete(); script_q.delete(); script_q.push_back(32'h24080001);
    gnt_wait = 0; rv_wait = 0;
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    @(negedge clk);
    chk32("f_c0_stall", {31'h0, stall}, 32'h1);
    chk32("f_c0_mem_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    chk32("f_c1_mem_req", {31'h0, mem_req}, 32'h1);
    chk32("f_c1_mem_addr", mem_addr, 32'hBFC00000);
    chk32("f_c1_mem_wen", {28'h0, mem_wen}, 32'h0);
    chk32("f_c1_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    chk32("f_c2_stall", {31'h0, stall}, 32'h1);
    chk32("f_c2_mem_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    chk32("f_c3_stall", {31'h0, stall}, 32'h0);
    chk32("f_c3_inst_rdata", inst_rdata, 32'h24080001);
    exp_inst = 32'h24080001;
    @(posedge clk);
    #1 inst_req = 1'b0;

    vecs[0] = '{1, 32'hBFC00000, 32'h24080001, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0, 3, 32'h24080001, 32'h0, 1};
    vecs[1] = '{1, 32'h00000004, 32'h5555FFFF, 1, 4'h0, 32'h10, 32'h0, 32'hAAAA0000, 0, 0, 6, 32'h5555FFFF, 32'hAAAA0000, 1};
    vecs[2] = '{1, 32'h00000008, 32'h11112222, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0, 3, 32'h11112222, 32'hAAAA0000, 1};
    vecs[3] = '{0, 32'h0, 32'h0, 1, 4'h3, 32'h20, 32'h12345678, 32'h0BADF00D, 2, 1, 6, 32'h11112222, 32'h0, 0};
    vecs[4] = '{0, 32'h0, 32'h0, 1, 4'h0, 32'h24, 32'h0, 32'h87654321, 1, 2, 6, 32'h11112222, 32'h87654321, 1};
    vecs[5] = '{0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h11112222, 32'h87654321, 1};
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].ireq, vecs[i].iaddr, vecs[i].iword, vecs[i].dreq, vecs[i].dwen,
             vecs[i].daddr, vecs[i].dwdata, vecs[i].dword, vecs[i].gw, vecs[i].rw, cyc);
      chk32("vec_cycles", 32'(cyc), 32'(vecs[i].exp_cycles));
      chk32("vec_inst_rdata", inst_rdata, vecs[i].exp_i);
      if (vecs[i].chk_d) chk32("vec_data_rdata", data_rdata, vecs[i].exp_d);
    end

    // Store with gnt delayed 2 and rvalid delayed 1: bus held for 3 cycles.
    log_q.delete(); script_q.delete(); script_q.push_back(32'h0);
    gnt_wait = 2; rv_wait = 1;
    data_req = 1'b1; data_wen = 4'h3; data_addr = 32'h30; data_wdata = 32'h12345678;
    @(negedge clk);
    chk32("s_c0_mem_req", {31'h0, mem_req}, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk32("s_hold_mem_req", {31'h0, mem_req}, 32'h1);
      chk32("s_hold_mem_wen", {28'h0, mem_wen}, 32'h3);
      chk32("s_hold_mem_wdata", mem_wdata, 32'h12345678);
      chk32("s_hold_mem_addr", mem_addr, 32'h30);
    end
    @(negedge clk);
    chk32("s_c4_mem_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    chk32("s_c5_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    chk32("s_c6_stall", {31'h0, stall}, 32'h0);
    chk32("s_inst_rdata_kept", inst_rdata, exp_inst);
    data_known = 0;
    @(posedge clk);
    #1 data_req = 1'b0;

    for (int n = 0; n < 40; n++) begin
      bit          ir, dr;
      logic [3:0]  wen;
      ir  = 1'($urandom % 2);
      dr  = 1'($urandom % 2);
      wen = ($urandom % 2) ? 4'h0 : 4'($urandom_range(1, 15));
      run_op(ir, $urandom & 32'hFFFFFFFC, $urandom, dr, wen, $urandom & 32'hFFFFFFFC,
             $urandom, $urandom, int'($urandom % 4), int'($urandom % 4), cyc);
    end

    // Reset while the load sits in D_RESP.
    log_q.delete(); script_q.delete(); script_q.push_back(32'hFEEDFACE);
    gnt_wait = 0; rv_wait = 3;
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h40; data_wdata = 32'h0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk32("mid_rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk32("mid_rst_inst_rdata", inst_rdata, 32'h0);
    chk32("mid_rst_data_rdata", data_rdata, 32'h0);
    chk32("mid_rst_stall", {31'h0, stall}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_inst = 32'h0; exp_data = 32'h0; data_known = 1;
    run_op(0, 32'h0, 32'h0, 1, 4'h0, 32'h40, 32'h0, 32'h600DD00D, 0, 0, cyc);
    chk32("reissue_cycles", 32'(cyc), 32'd3);
    chk32("reissue_data_rdata", data_rdata, 32'h600DD00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
